// File: rtl/instr_mem_loader_pkg.sv
`timescale 1ns/1ps
// instr_mem_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   loader_state_t   : loader FSM states
//   HDR_BYTES        : length of the word-count header in the byte stream
//   BYTES_PER_INSTR  : bytes per instruction word (also the wr_addr stride)
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    WORD   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loader_state_t;

  localparam int HDR_BYTES       = 2;
  localparam int BYTES_PER_INSTR = 4;

endpackage

// File: rtl/instr_mem_loader.sv
`timescale 1ns/1ps
// instr_mem_loader
// Writer side of the instruction memory. Receives a big-endian byte stream
// (16-bit word count N, then N 32-bit words) and writes each word into the
// instr_mem write port while holding the core in reset. The core is released
// once the image is complete so it boots from pc = 0.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_load_start          pulse: start a load from IDLE / DONE / ERROR
//   i_in_valid, i_in_data byte source
//   o_in_ready            byte accepted this cycle (state-only decode)
//   o_wr_en/addr/data     instr_mem write port, one strobe per word
//   o_cpu_rst             reset to the processor core
//   o_busy                load in progress
//   o_done, o_error       sticky status of the last load
//
// state  | meaning
// -------+-----------------------------------------------------
// IDLE   | after reset, nothing loaded, core free
// HDR_HI | waiting for word-count MSB
// HDR_LO | waiting for word-count LSB, N validated on arrival
// WORD   | collecting the 4 bytes of one instruction
// WRITE  | one-cycle write strobe to instr_mem
// DONE   | image complete, core released
// ERROR  | header exceeded capacity, core held in reset
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_SIZE   = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load_start,
  input  logic                   i_in_valid,
  input  logic [7:0]             i_in_data,
  output logic                   o_in_ready,
  output logic                   o_wr_en,
  output logic [ADDR_WIDTH-1:0]  o_wr_addr,
  output logic [INSTR_WIDTH-1:0] o_wr_data,
  output logic                   o_cpu_rst,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error
);

  localparam logic [15:0] MAX_WORDS = 16'(ADDR_SIZE / BYTES_PER_INSTR);

  loader_state_t          r_state;
  logic                   r_in_ready;
  logic                   r_wr_en;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic [INSTR_WIDTH-1:0] r_shift;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic                   r_cpu_hold;
  logic [1:0]             r_byte_cnt;
  logic [15:0]            r_word_cnt;
  logic [15:0]            r_num_words;
  logic [7:0]             r_hdr_hi;

  logic                   w_accept;
  logic [15:0]            w_hdr;
  logic [15:0]            w_word_cnt_nxt;

  assign w_accept       = i_in_valid & r_in_ready;
  assign w_hdr          = {r_hdr_hi, i_in_data};
  assign w_word_cnt_nxt = r_word_cnt + 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_shift     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_hold  <= 1'b0;
      r_byte_cnt  <= 2'd0;
      r_word_cnt  <= 16'd0;
      r_num_words <= 16'd0;
      r_hdr_hi    <= 8'd0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (i_load_start) begin
            r_state    <= HDR_HI;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_word_cnt <= 16'd0;
            r_wr_addr  <= '0;
            r_byte_cnt <= 2'd0;
          end
        end
        HDR_HI: begin
          if (w_accept) begin
            r_hdr_hi <= i_in_data;
            r_state  <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (w_accept) begin
            r_num_words <= w_hdr;
            if (w_hdr == 16'd0) begin
              r_state    <= DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else if (w_hdr > MAX_WORDS) begin
              // Core stays in reset: the memory image is not trustworthy.
              r_state    <= ERROR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state <= WORD;
            end
          end
        end
        WORD: begin
          if (w_accept) begin
            // Big-endian: earlier bytes migrate toward the MSB.
            r_shift <= {r_shift[INSTR_WIDTH-9:0], i_in_data};
            if (r_byte_cnt == 2'd3) begin
              r_state    <= WRITE;
              r_in_ready <= 1'b0;
              r_wr_en    <= 1'b1;
              r_byte_cnt <= 2'd0;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          r_word_cnt <= w_word_cnt_nxt;
          if (w_word_cnt_nxt == r_num_words) begin
            // wr_addr is left on the last written word.
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end else begin
            r_state    <= WORD;
            r_in_ready <= 1'b1;
            r_wr_addr  <= r_wr_addr + ADDR_WIDTH'(BYTES_PER_INSTR);
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_shift;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_error    = r_error;
  // rst is ORed in directly so the core stays reset for as long as rst is high.
  assign o_cpu_rst  = i_rst | r_cpu_hold;

endmodule
